// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, HI/LO handling and multiply, plus a
// 32-step restoring divider that stalls the pipeline while it iterates.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_AND   = 8'b00100100, OP_OR    = 8'b00100101,
                           OP_XOR   = 8'b00100110, OP_NOR   = 8'b00100111,
                           OP_SLL   = 8'b01111100, OP_SLLV  = 8'b00000100,
                           OP_SRL   = 8'b00000010, OP_SRLV  = 8'b00000110,
                           OP_SRA   = 8'b00000011, OP_SRAV  = 8'b00000111,
                           OP_MOVZ  = 8'b00001010, OP_MOVN  = 8'b00001011,
                           OP_MFHI  = 8'b00010000, OP_MTHI  = 8'b00010001,
                           OP_MFLO  = 8'b00010010, OP_MTLO  = 8'b00010011,
                           OP_SLT   = 8'b00101010, OP_SLTU  = 8'b00101011,
                           OP_SLTI  = 8'b01010111, OP_SLTIU = 8'b01011000,
                           OP_ADD   = 8'b00100000, OP_ADDU  = 8'b00100001,
                           OP_SUB   = 8'b00100010, OP_SUBU  = 8'b00100011,
                           OP_ADDI  = 8'b01010101, OP_ADDIU = 8'b01010110,
                           OP_CLZ   = 8'b10110000, OP_CLO   = 8'b10110001,
                           OP_MULT  = 8'b00011000, OP_MULTU = 8'b00011001,
                           OP_MUL   = 8'b10101001, OP_DIV   = 8'b00011010,
                           OP_DIVU  = 8'b00011011;
    localparam logic [2:0] RES_LOGIC = 3'b001, RES_SHIFT = 3'b010, RES_MOVE = 3'b011,
                           RES_ARITH = 3'b100, RES_MUL   = 3'b101;

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} div_state_t;

    div_state_t  state, next_state;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dvs;
    logic        q_neg, r_neg;
    logic        div_stall;

    logic        div_op, div_signed;
    logic [31:0] abs1, abs2;
    logic [32:0] trial;
    logic [31:0] sel_hi, sel_lo, sum, diff;
    logic [63:0] prod_s, prod_u;
    logic        add_ovf, sub_ovf, ovf;
    logic [31:0] logic_res, shift_res, move_res, arith_res, wdata_c, hi_c, lo_c;
    logic        whilo_c;

    function automatic logic [5:0] count_lead(input logic [31:0] v, input logic b);
        logic [5:0] n;
        logic       done;
        n = 6'd0;
        done = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!done) begin
                if (v[i] == b) n = n + 6'd1;
                else done = 1'b1;
            end
        end
        return n;
    endfunction

    assign div_op     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign div_signed = (aluop_i == OP_DIV);
    assign abs1       = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign abs2       = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
    assign trial      = {rem, quo[31]} - {1'b0, dvs};

    always_comb begin
        next_state = state;
        div_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (div_op) begin
                    div_stall  = 1'b1;
                    next_state = (reg2_i == 32'd0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                div_stall  = 1'b1;
                next_state = END;
            end
            ON: begin
                div_stall = 1'b1;
                if (cnt == 6'd31) next_state = END;
            end
            END:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are captured only in IDLE, so held inputs during a stall are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 6'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            dvs   <= 32'd0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (div_op && reg2_i != 32'd0) begin
                        quo   <= abs1;
                        dvs   <= abs2;
                        rem   <= 32'd0;
                        q_neg <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                        r_neg <= div_signed && reg1_i[31];
                        cnt   <= 6'd0;
                    end
                end
                DIVZERO: begin
                    quo   <= 32'd0;
                    rem   <= 32'd0;
                    q_neg <= 1'b0;
                    r_neg <= 1'b0;
                end
                ON: begin
                    cnt <= cnt + 6'd1;
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], quo[31]};
                        quo <= {quo[30:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_hi  = mem_whilo_i ? mem_hi_i : hi_i;
    assign sel_lo  = mem_whilo_i ? mem_lo_i : lo_i;
    assign sum     = reg1_i + reg2_i;
    assign diff    = reg1_i - reg2_i;
    assign prod_s  = $signed(reg1_i) * $signed(reg2_i);
    assign prod_u  = reg1_i * reg2_i;
    assign add_ovf = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign sub_ovf = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
    assign ovf     = ((aluop_i == OP_ADD || aluop_i == OP_ADDI) && add_ovf)
                   || ((aluop_i == OP_SUB) && sub_ovf);

    always_comb begin
        logic_res = 32'd0;
        shift_res = 32'd0;
        move_res  = 32'd0;
        arith_res = 32'd0;
        case (aluop_i)
            OP_OR:  logic_res = reg1_i | reg2_i;
            OP_AND: logic_res = reg1_i & reg2_i;
            OP_XOR: logic_res = reg1_i ^ reg2_i;
            OP_NOR: logic_res = ~(reg1_i | reg2_i);
            default: ;
        endcase
        case (aluop_i)
            OP_SLL, OP_SLLV: shift_res = reg2_i << reg1_i[4:0];
            OP_SRL, OP_SRLV: shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA, OP_SRAV: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: ;
        endcase
        case (aluop_i)
            OP_MFHI:          move_res = sel_hi;
            OP_MFLO:          move_res = sel_lo;
            OP_MOVZ, OP_MOVN: move_res = reg1_i;
            default: ;
        endcase
        case (aluop_i)
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: arith_res = sum;
            OP_SUB, OP_SUBU:   arith_res = diff;
            OP_SLT, OP_SLTI:   arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU, OP_SLTIU: arith_res = {31'd0, reg1_i < reg2_i};
            OP_CLZ:            arith_res = {26'd0, count_lead(reg1_i, 1'b0)};
            OP_CLO:            arith_res = {26'd0, count_lead(reg1_i, 1'b1)};
            default: ;
        endcase
    end

    always_comb begin
        wdata_c = 32'd0;
        case (alusel_i)
            RES_LOGIC: wdata_c = logic_res;
            RES_SHIFT: wdata_c = shift_res;
            RES_MOVE:  wdata_c = move_res;
            RES_ARITH: wdata_c = arith_res;
            RES_MUL:   wdata_c = prod_s[31:0];
            default: ;
        endcase
    end

    // A finished divide takes priority; the DIV opcode is still on the inputs then.
    always_comb begin
        whilo_c = 1'b0;
        hi_c    = 32'd0;
        lo_c    = 32'd0;
        if (state == END) begin
            whilo_c = 1'b1;
            hi_c    = r_neg ? -rem : rem;
            lo_c    = q_neg ? -quo : quo;
        end else begin
            case (aluop_i)
                OP_MULT:  begin whilo_c = 1'b1; {hi_c, lo_c} = prod_s; end
                OP_MULTU: begin whilo_c = 1'b1; {hi_c, lo_c} = prod_u; end
                OP_MTHI:  begin whilo_c = 1'b1; hi_c = reg1_i; lo_c = sel_lo; end
                OP_MTLO:  begin whilo_c = 1'b1; hi_c = sel_hi; lo_c = reg1_i; end
                default: ;
            endcase
        end
    end

    assign wd_o       = rst ? 5'd0  : wd_i;
    assign wreg_o     = rst ? 1'b0  : (wreg_i && !ovf);
    assign wdata_o    = rst ? 32'd0 : wdata_c;
    assign whilo_o    = rst ? 1'b0  : whilo_c;
    assign hi_o       = rst ? 32'd0 : hi_c;
    assign lo_o       = rst ? 32'd0 : lo_c;
    assign stallreq_o = rst ? 1'b0  : div_stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: combinational ALU vectors, HI/LO forwarding,
// divider latency/results and a mid-divide reset abort.
module tb_ex_stage;
    localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'b00100101, OP_NOR = 8'b00100111,
                           OP_SLL = 8'b01111100, OP_SRA = 8'b00000011,
                           OP_MFHI = 8'b00010000, OP_MFLO = 8'b00010010,
                           OP_MTHI = 8'b00010001, OP_SLT = 8'b00101010,
                           OP_SLTU = 8'b00101011, OP_ADD = 8'b00100000,
                           OP_ADDU = 8'b00100001, OP_SUB = 8'b00100010,
                           OP_CLZ = 8'b10110000, OP_CLO = 8'b10110001,
                           OP_MULT = 8'b00011000, OP_MULTU = 8'b00011001,
                           OP_MUL = 8'b10101001, OP_DIV = 8'b00011010,
                           OP_DIVU = 8'b00011011;
    localparam logic [2:0] RES_NOP = 3'b000, RES_LOGIC = 3'b001, RES_SHIFT = 3'b010,
                           RES_MOVE = 3'b011, RES_ARITH = 3'b100, RES_MUL = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i, mem_hi_i, mem_lo_i;
    logic [4:0]  wd_i;
    logic        wreg_i, mem_whilo_i;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int errors = 0;
    int checks = 0;
    int stall_cycles;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i), .mem_whilo_i(mem_whilo_i),
        .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic [7:0] op, input logic [2:0] sel,
                                  input logic [31:0] r1, input logic [31:0] r2);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues a divide on a negedge and counts stalled cycles up to a bound.
    task automatic run_divide(input logic [7:0] op, input logic [31:0] r1,
                              input logic [31:0] r2);
        @(negedge clk);
        apply_stimulus(op, RES_NOP, r1, r2);
        stall_cycles = 0;
        while (stallreq_o === 1'b1 && stall_cycles < 40) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        wd_i = 5'd3; wreg_i = 1'b1;
        hi_i = 32'h11; lo_i = 32'h33;
        mem_whilo_i = 1'b0; mem_hi_i = 32'h22; mem_lo_i = 32'h44;
        apply_stimulus(OP_ADD, RES_ARITH, 32'h5, 32'h6);
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_wd", {27'd0, wd_o}, 32'd0);
        check_output("rst_wreg", {31'd0, wreg_o}, 32'd0);
        check_output("rst_wdata", wdata_o, 32'd0);
        check_output("rst_whilo", {31'd0, whilo_o}, 32'd0);
        check_output("rst_stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;

        apply_stimulus(OP_ADD, RES_ARITH, 32'h7FFFFFFF, 32'h1);
        check_output("add_ovf_wdata", wdata_o, 32'h80000000);
        check_output("add_ovf_wreg", {31'd0, wreg_o}, 32'd0);
        check_output("add_wd", {27'd0, wd_o}, 32'd3);
        apply_stimulus(OP_ADDU, RES_ARITH, 32'h7FFFFFFF, 32'h1);
        check_output("addu_wreg", {31'd0, wreg_o}, 32'd1);
        apply_stimulus(OP_SUB, RES_ARITH, 32'h80000000, 32'h1);
        check_output("sub_ovf_wdata", wdata_o, 32'h7FFFFFFF);
        check_output("sub_ovf_wreg", {31'd0, wreg_o}, 32'd0);
        apply_stimulus(OP_SRA, RES_SHIFT, 32'd4, 32'hF0000000);
        check_output("sra", wdata_o, 32'hFF000000);
        apply_stimulus(OP_SLL, RES_SHIFT, 32'd4, 32'h1);
        check_output("sll", wdata_o, 32'h10);
        apply_stimulus(OP_CLZ, RES_ARITH, 32'h00010000, 32'h0);
        check_output("clz", wdata_o, 32'd15);
        apply_stimulus(OP_CLZ, RES_ARITH, 32'h0, 32'h0);
        check_output("clz_zero", wdata_o, 32'd32);
        apply_stimulus(OP_CLO, RES_ARITH, 32'hFFFFFFFF, 32'h0);
        check_output("clo_ones", wdata_o, 32'd32);
        apply_stimulus(OP_SLT, RES_ARITH, 32'hFFFFFFFF, 32'h1);
        check_output("slt", wdata_o, 32'd1);
        apply_stimulus(OP_SLTU, RES_ARITH, 32'hFFFFFFFF, 32'h1);
        check_output("sltu", wdata_o, 32'd0);
        apply_stimulus(OP_OR, RES_LOGIC, 32'h0, 32'h12340000);
        check_output("lui_or", wdata_o, 32'h12340000);
        apply_stimulus(OP_NOR, RES_LOGIC, 32'h0, 32'h0F0F0F0F);
        check_output("nor", wdata_o, 32'hF0F0F0F0);
        check_output("logic_whilo", {31'd0, whilo_o}, 32'd0);

        apply_stimulus(OP_MULT, RES_NOP, 32'hFFFFFFFE, 32'd3);
        check_output("mult_whilo", {31'd0, whilo_o}, 32'd1);
        check_output("mult_hi", hi_o, 32'hFFFFFFFF);
        check_output("mult_lo", lo_o, 32'hFFFFFFFA);
        apply_stimulus(OP_MULTU, RES_NOP, 32'hFFFFFFFE, 32'd3);
        check_output("multu_hi", hi_o, 32'h2);
        check_output("multu_lo", lo_o, 32'hFFFFFFFA);
        apply_stimulus(OP_MUL, RES_MUL, 32'hFFFFFFFE, 32'd3);
        check_output("mul", wdata_o, 32'hFFFFFFFA);
        apply_stimulus(OP_NOP, RES_NOP, 32'h5, 32'h6);
        check_output("nop", wdata_o, 32'd0);

        mem_whilo_i = 1'b1;
        apply_stimulus(OP_MFHI, RES_MOVE, 32'h0, 32'h0);
        check_output("mfhi_fwd", wdata_o, 32'h22);
        mem_whilo_i = 1'b0;
        apply_stimulus(OP_MFLO, RES_MOVE, 32'h0, 32'h0);
        check_output("mflo", wdata_o, 32'h33);
        apply_stimulus(OP_MTHI, RES_NOP, 32'hAB, 32'h0);
        check_output("mthi_hi", hi_o, 32'hAB);
        check_output("mthi_lo", lo_o, 32'h33);

        run_divide(OP_DIV, 32'hFFFFFFF9, 32'd2);
        check_output("div_stalls", stall_cycles, 32'd33);
        check_output("div_whilo", {31'd0, whilo_o}, 32'd1);
        check_output("div_lo", lo_o, 32'hFFFFFFFD);
        check_output("div_hi", hi_o, 32'hFFFFFFFF);
        aluop_i = OP_NOP;

        run_divide(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        check_output("div_min_lo", lo_o, 32'h80000000);
        check_output("div_min_hi", hi_o, 32'h0);
        aluop_i = OP_NOP;

        run_divide(OP_DIVU, 32'd5, 32'd0);
        check_output("div0_stalls", stall_cycles, 32'd2);
        check_output("div0_whilo", {31'd0, whilo_o}, 32'd1);
        check_output("div0_hi", hi_o, 32'd0);
        check_output("div0_lo", lo_o, 32'd0);
        aluop_i = OP_NOP;

        @(negedge clk);
        apply_stimulus(OP_DIVU, RES_NOP, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        #1;
        check_output("abort_mid_stall", {31'd0, stallreq_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_output("abort_rst_stall", {31'd0, stallreq_o}, 32'd0);
        check_output("abort_rst_lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(OP_NOP, RES_NOP, 32'd0, 32'd0);
        check_output("abort_idle", {31'd0, stallreq_o}, 32'd0);

        run_divide(OP_DIVU, 32'd100, 32'd7);
        check_output("divu_stalls", stall_cycles, 32'd33);
        check_output("divu_lo", lo_o, 32'd14);
        check_output("divu_hi", hi_o, 32'd2);
        aluop_i = OP_NOP;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
